mastermind_control_param: RTL

- Parametrised game-sequencing FSM for the Mastermind datapath.
- Generalises the fixed 4-peg control to NUM_PEGS pegs.
- Adds a guess counter with a MAX_GUESSES limit, win/lose terminal state, new_game restart and a compare-complete flag.
- Drives the code/guess register-file load strobes and the per-peg compare sequencing; consumes the datapath's exact_match result.

---
 rtl/mastermind_control_param.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mastermind_control_param.sv
// mastermind_control_param
//   Game-sequencing controller for the Mastermind datapath, parametrised on
//   peg count and guess limit. Walks the player through code entry, repeated
//   guess entry, per-peg comparison and a win/lose terminal state.
//
// State table
//   state          | meaning
//   ---------------+-------------------------------------------------------
//   LOAD_CODE      | strobe load_code for peg slot, wait for key press
//   LOAD_CODE_WAIT | key held, wait for release, then advance slot
//   GUESS          | strobe load_guess for peg slot, wait for key press
//   GUESS_WAIT     | key held, wait for release, then advance slot
//   COMPARE        | sweep compare_i over all pegs, one per cycle
//   CHECK          | count the guess, decide win / lose / next guess
//   GAME_OVER      | terminal, left only through new_game or reset
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   load           in   debounced player key (level)
//   new_game       in   restart request (level)
//   exact_match    in   datapath: all pegs match, sampled in CHECK
//   load_code      out  write code peg slot_idx
//   load_guess     out  write guess peg slot_idx
//   slot_idx       out  peg slot being loaded
//   compare        out  datapath compares peg compare_i this cycle
//   compare_i      out  peg index under comparison
//   compare_done   out  last compare cycle
//   guess_count    out  completed guesses this game
//   game_over      out  game finished
//   win            out  game won (meaningful with game_over)

module mastermind_control_param #(
    parameter int NUM_PEGS    = 4,
    parameter int MAX_GUESSES = 10,
    localparam int IDX_W      = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1,
    localparam int CNT_W      = $clog2(MAX_GUESSES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             new_game,
    input  logic             exact_match,
    output logic             load_code,
    output logic             load_guess,
    output logic [IDX_W-1:0] slot_idx,
    output logic             compare,
    output logic [IDX_W-1:0] compare_i,
    output logic             compare_done,
    output logic [CNT_W-1:0] guess_count,
    output logic             game_over,
    output logic             win
);

    typedef enum logic [2:0] {
        ST_LOAD_CODE      = 3'd0,
        ST_LOAD_CODE_WAIT = 3'd1,
        ST_GUESS          = 3'd2,
        ST_GUESS_WAIT     = 3'd3,
        ST_COMPARE        = 3'd4,
        ST_CHECK          = 3'd5,
        ST_GAME_OVER      = 3'd6
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PEGS - 1);
    localparam logic [CNT_W-1:0] LAST_GUESS = CNT_W'(MAX_GUESSES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] slot_q, slot_d;
    logic [IDX_W-1:0] cmp_q, cmp_d;
    logic [CNT_W-1:0] guess_cnt_q, guess_cnt_d;
    logic             win_q, win_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD_CODE;
            slot_q      <= '0;
            cmp_q       <= '0;
            guess_cnt_q <= '0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cmp_q       <= cmp_d;
            guess_cnt_q <= guess_cnt_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cmp_d       = cmp_q;
        guess_cnt_d = guess_cnt_q;
        win_d       = win_q;

        if (new_game) begin
            // Restart outranks every state, including a pending key press.
            state_d     = ST_LOAD_CODE;
            slot_d      = '0;
            cmp_d       = '0;
            guess_cnt_d = '0;
            win_d       = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_CODE: begin
                    if (load) state_d = ST_LOAD_CODE_WAIT;
                end
                ST_LOAD_CODE_WAIT: begin
                    if (!load) begin
                        if (slot_q == LAST_IDX) begin
                            slot_d  = '0;
                            state_d = ST_GUESS;
                        end else begin
                            slot_d  = slot_q + IDX_W'(1);
                            state_d = ST_LOAD_CODE;
                        end
                    end
                end
                ST_GUESS: begin
                    if (load) state_d = ST_GUESS_WAIT;
                end
                ST_GUESS_WAIT: begin
                    if (!load) begin
                        if (slot_q == LAST_IDX) begin
                            slot_d  = '0;
                            cmp_d   = '0;
                            state_d = ST_COMPARE;
                        end else begin
                            slot_d  = slot_q + IDX_W'(1);
                            state_d = ST_GUESS;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (cmp_q == LAST_IDX) begin
                        cmp_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        cmp_d = cmp_q + IDX_W'(1);
                    end
                end
                ST_CHECK: begin
                    guess_cnt_d = guess_cnt_q + CNT_W'(1);
                    // A match on the final allowed guess still counts as a win.
                    if (exact_match) begin
                        win_d   = 1'b1;
                        state_d = ST_GAME_OVER;
                    end else if (guess_cnt_q == LAST_GUESS) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_GUESS;
                    end
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                end
                default: begin
                    state_d = ST_LOAD_CODE;
                end
            endcase
        end
    end

    logic in_load_state;
    logic in_compare;

    assign in_load_state = (state_q == ST_LOAD_CODE) || (state_q == ST_LOAD_CODE_WAIT) ||
                           (state_q == ST_GUESS)     || (state_q == ST_GUESS_WAIT);
    assign in_compare    = (state_q == ST_COMPARE);

    assign load_code    = (state_q == ST_LOAD_CODE);
    assign load_guess   = (state_q == ST_GUESS);
    assign slot_idx     = in_load_state ? slot_q : '0;
    assign compare      = in_compare;
    assign compare_i    = in_compare ? cmp_q : '0;
    assign compare_done = in_compare && (cmp_q == LAST_IDX);
    assign guess_count  = guess_cnt_q;
    assign game_over    = (state_q == ST_GAME_OVER);
    assign win          = win_q;

endmodule
